// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite scratch memory slave with byte/half/word writes,
// programmable OKAY wait states and the two-cycle ERROR response for misaligned or oversized accesses.
module ahb_lite_sram_slave #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);
  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam logic [2:0] WS = 3'(WAIT_STATES);
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_e;
  state_e state_q, state_d, start_st;
  logic [2:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic write_q, write_d;
  logic [2:0] size_q, size_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] word_d;
  logic [3:0] be;
  logic accept, illegal, we;
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_W], HTRANS[0]};
  assign accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign illegal = (HSIZE > 3'd2) | ((HSIZE == 3'd1) & HADDR[0]) | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
  assign start_st = illegal ? ERR1 : (WAIT_STATES > 0 ? WAIT : DATA);
  assign HREADYOUT = (state_q != WAIT) & (state_q != ERR1);
  assign HRESP = (state_q == ERR1 || state_q == ERR2) ? 2'b01 : 2'b00;
  assign HRDATA = state_q == DATA ? mem_q[addr_q[ADDR_W-1:2]] : 32'h0;
  assign we = (state_q == DATA) & write_q;
  always_comb begin
    addr_d  = accept ? HADDR[ADDR_W-1:0] : addr_q;
    write_d = accept ? HWRITE : write_q;
    size_d  = accept ? HSIZE : size_q;
    state_d = state_q == WAIT ? (cnt_q == WS ? DATA : WAIT) :
              state_q == ERR1 ? ERR2 :
              accept          ? start_st : IDLE;
    cnt_d   = state_d == WAIT ? cnt_q + 3'd1 : 3'd0;
  end
  // Lane enables follow little-endian byte order within the addressed word
  always_comb begin
    be = size_q == 3'd0 ? 4'b0001 << addr_q[1:0] :
         size_q == 3'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    word_d = mem_q[addr_q[ADDR_W-1:2]];
    for (int i = 0; i < 4; i++)
      if (be[i]) word_d[8*i +: 8] = HWDATA[8*i +: 8];
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end
  // Array is deliberately unreset; reset only forces IDLE so a pending write never lands
  always_ff @(posedge HCLK) begin
    if (we) mem_q[addr_q[ADDR_W-1:2]] <= word_d;
  end
endmodule
